// File: rtl/tinyriscv_pkg.sv
// rtl/tinyriscv_pkg.sv - shared tinyriscv defines, region codes and ALU helper
package tinyriscv_pkg;

   localparam int RegBusW = 32;
   typedef logic [RegBusW-1:0] reg_bus_t;

   localparam reg_bus_t   ZeroWord   = 32'h0000_0000;
   localparam logic       RstEnable  = 1'b1;
   localparam logic       RstDisable = 1'b0;
   localparam logic [3:0] RegionRom  = 4'h0;
   localparam logic [3:0] RegionRam  = 4'h1;
   localparam int         IdxW       = 12;

   typedef enum logic [6:0] {
      OP_LUI    = 7'h37,
      OP_AUIPC  = 7'h17,
      OP_JAL    = 7'h6f,
      OP_JALR   = 7'h67,
      OP_BRANCH = 7'h63,
      OP_LOAD   = 7'h03,
      OP_STORE  = 7'h23,
      OP_IMM    = 7'h13,
      OP_REG    = 7'h33
   } opcode_e;

   // Integer ALU shared by register-register and register-immediate forms
   function automatic reg_bus_t alu_op(input logic [2:0] funct3, input logic alt,
                                       input reg_bus_t a, input reg_bus_t b);
      reg_bus_t r;
      case (funct3)
         3'b000:  r = alt ? (a - b) : (a + b);
         3'b001:  r = a << b[4:0];
         3'b010:  r = {31'b0, $signed(a) < $signed(b)};
         3'b011:  r = {31'b0, a < b};
         3'b100:  r = a ^ b;
         3'b101:  begin
                     if (alt) r = $signed(a) >>> b[4:0];
                     else     r = a >> b[4:0];
                  end
         3'b110:  r = a | b;
         default: r = a & b;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/ram.sv
// rtl/ram.sv - data RAM, two combinational read ports, word write from the data port
module ram
   import tinyriscv_pkg::*;
#(
   parameter int DEPTH = 4096
) (
   input  logic            clk,
   input  logic [IdxW-1:0] fetch_idx_i,
   output logic [31:0]     fetch_rdata_o,
   input  logic [IdxW-1:0] data_idx_i,
   output logic [31:0]     data_rdata_o,
   input  logic            we_i,
   input  logic [31:0]     wdata_i
);

   localparam int AW = $clog2(DEPTH);

   logic [31:0] _ram [0:DEPTH-1];

   assign fetch_rdata_o = _ram[fetch_idx_i[AW-1:0]];
   assign data_rdata_o  = _ram[data_idx_i[AW-1:0]];

   // Full-word store, not gated by reset
   always_ff @(posedge clk) begin
      if (we_i) _ram[data_idx_i[AW-1:0]] <= wdata_i;
   end

endmodule

// File: rtl/rom.sv
// rtl/rom.sv - program ROM, two combinational read ports, word write from the data port
module rom
   import tinyriscv_pkg::*;
#(
   parameter int DEPTH = 4096
) (
   input  logic            clk,
   input  logic [IdxW-1:0] fetch_idx_i,
   output logic [31:0]     fetch_rdata_o,
   input  logic [IdxW-1:0] data_idx_i,
   output logic [31:0]     data_rdata_o,
   input  logic            we_i,
   input  logic [31:0]     wdata_i
);

   localparam int AW = $clog2(DEPTH);

   logic [31:0] _rom [0:DEPTH-1];

   assign fetch_rdata_o = _rom[fetch_idx_i[AW-1:0]];
   assign data_rdata_o  = _rom[data_idx_i[AW-1:0]];

   // Full-word store, not gated by reset
   always_ff @(posedge clk) begin
      if (we_i) _rom[data_idx_i[AW-1:0]] <= wdata_i;
   end

endmodule

// File: rtl/soc_bus_decoder.sv
// rtl/soc_bus_decoder.sv - region select, read mux and write gating for fetch and data ports
module soc_bus_decoder
   import tinyriscv_pkg::*;
(
   input  logic [31:0]     fetch_addr_i,
   output logic [31:0]     fetch_data_o,
   input  logic [31:0]     data_addr_i,
   input  logic            data_req_i,
   input  logic            data_we_i,
   output logic [31:0]     data_rdata_o,
   output logic [IdxW-1:0] fetch_idx_o,
   output logic [IdxW-1:0] data_idx_o,
   input  logic [31:0]     rom_fetch_rdata_i,
   input  logic [31:0]     rom_data_rdata_i,
   input  logic [31:0]     ram_fetch_rdata_i,
   input  logic [31:0]     ram_data_rdata_i,
   output logic            rom_we_o,
   output logic            ram_we_o
);

   logic unused_addr_bits;
   assign unused_addr_bits = ^{fetch_addr_i[27:14], fetch_addr_i[1:0],
                               data_addr_i[27:14], data_addr_i[1:0]};

   assign fetch_idx_o = fetch_addr_i[13:2];
   assign data_idx_o  = data_addr_i[13:2];

   // Unmapped regions read as zero and swallow writes
   always_comb begin
      fetch_data_o = ZeroWord;
      data_rdata_o = ZeroWord;
      rom_we_o     = 1'b0;
      ram_we_o     = 1'b0;
      case (fetch_addr_i[31:28])
         RegionRom: fetch_data_o = rom_fetch_rdata_i;
         RegionRam: fetch_data_o = ram_fetch_rdata_i;
         default:   fetch_data_o = ZeroWord;
      endcase
      case (data_addr_i[31:28])
         RegionRom: begin
            data_rdata_o = rom_data_rdata_i;
            rom_we_o     = data_req_i & data_we_i;
         end
         RegionRam: begin
            data_rdata_o = ram_data_rdata_i;
            ram_we_o     = data_req_i & data_we_i;
         end
         default: data_rdata_o = ZeroWord;
      endcase
   end

endmodule

// File: rtl/tinyriscv.sv
// rtl/tinyriscv.sv - RV32I core, one instruction per cycle with combinational memory access
module tinyriscv
   import tinyriscv_pkg::*;
(
   input  logic     clk,
   input  logic     rst,
   output reg_bus_t pc_addr,
   input  reg_bus_t pc_data,
   output reg_bus_t ex_addr,
   output reg_bus_t ex_wdata,
   output logic     ex_we,
   output logic     ex_req,
   input  reg_bus_t ex_rdata,
   input  logic     rib_hold_flag_i,
   input  logic     int_i
);

   reg_bus_t pc_q, pc_d;
   reg_bus_t inst, rs1_v, rs2_v, rd_wdata, mem_addr, ld_shift;
   reg_bus_t imm_i, imm_s, imm_b, imm_u, imm_j;
   logic [2:0] funct3;
   logic [4:0] byte_sh;
   logic       rd_we, take;
   logic       unused_core_bits;

   assign inst    = pc_data;
   assign pc_addr = pc_q;
   assign funct3  = inst[14:12];
   assign imm_i   = {{20{inst[31]}}, inst[31:20]};
   assign imm_s   = {{20{inst[31]}}, inst[31:25], inst[11:7]};
   assign imm_b   = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
   assign imm_u   = {inst[31:12], 12'b0};
   assign imm_j   = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

   // Sub-word accesses work on the containing word; stores merge into the old word
   assign mem_addr = rs1_v + ((inst[6:0] == OP_STORE) ? imm_s : imm_i);
   assign ex_addr  = mem_addr;
   assign byte_sh  = {mem_addr[1:0], 3'b000};
   assign ld_shift = ex_rdata >> byte_sh;

   assign unused_core_bits = ^{int_i, ld_shift[31:16]};

   tinyriscv_regs u_regs (
      .clk      (clk),
      .we_i     (rd_we & (rst == RstDisable)),
      .waddr_i  (inst[11:7]),
      .wdata_i  (rd_wdata),
      .raddr1_i (inst[19:15]),
      .rdata1_o (rs1_v),
      .raddr2_i (inst[24:20]),
      .rdata2_o (rs2_v)
   );

   // Decode and execute the current instruction; debug hold freezes PC, registers and stores
   always_comb begin
      pc_d     = pc_q + 32'd4;
      rd_we    = 1'b0;
      rd_wdata = ZeroWord;
      ex_wdata = ZeroWord;
      ex_req   = 1'b0;
      ex_we    = 1'b0;
      take     = 1'b0;
      case (opcode_e'(inst[6:0]))
         OP_LUI:   begin rd_we = 1'b1; rd_wdata = imm_u; end
         OP_AUIPC: begin rd_we = 1'b1; rd_wdata = pc_q + imm_u; end
         OP_JAL:   begin rd_we = 1'b1; rd_wdata = pc_q + 32'd4; pc_d = pc_q + imm_j; end
         OP_JALR:  begin rd_we = 1'b1; rd_wdata = pc_q + 32'd4; pc_d = (rs1_v + imm_i) & ~32'd1; end
         OP_BRANCH: begin
            case (funct3)
               3'b000:  take = (rs1_v == rs2_v);
               3'b001:  take = (rs1_v != rs2_v);
               3'b100:  take = ($signed(rs1_v) <  $signed(rs2_v));
               3'b101:  take = ($signed(rs1_v) >= $signed(rs2_v));
               3'b110:  take = (rs1_v <  rs2_v);
               3'b111:  take = (rs1_v >= rs2_v);
               default: take = 1'b0;
            endcase
            if (take) pc_d = pc_q + imm_b;
         end
         OP_LOAD: begin
            ex_req = 1'b1;
            rd_we  = 1'b1;
            case (funct3)
               3'b000:  rd_wdata = {{24{ld_shift[7]}}, ld_shift[7:0]};
               3'b001:  rd_wdata = {{16{ld_shift[15]}}, ld_shift[15:0]};
               3'b100:  rd_wdata = {24'b0, ld_shift[7:0]};
               3'b101:  rd_wdata = {16'b0, ld_shift[15:0]};
               default: rd_wdata = ex_rdata;
            endcase
         end
         OP_STORE: begin
            ex_req = 1'b1;
            ex_we  = 1'b1;
            case (funct3)
               3'b000:  ex_wdata = (ex_rdata & ~(32'h0000_00ff << byte_sh)) | ({24'b0, rs2_v[7:0]} << byte_sh);
               3'b001:  ex_wdata = (ex_rdata & ~(32'h0000_ffff << byte_sh)) | ({16'b0, rs2_v[15:0]} << byte_sh);
               default: ex_wdata = rs2_v;
            endcase
         end
         OP_IMM: begin
            rd_we    = 1'b1;
            rd_wdata = alu_op(funct3, (funct3 == 3'b101) & inst[30], rs1_v, imm_i);
         end
         OP_REG: begin
            rd_we    = 1'b1;
            rd_wdata = alu_op(funct3, inst[30], rs1_v, rs2_v);
         end
         default: ;
      endcase
      if (rib_hold_flag_i) begin
         pc_d  = pc_q;
         rd_we = 1'b0;
         ex_we = 1'b0;
      end
   end

   // Program counter
   always_ff @(posedge clk) begin
      if (rst == RstEnable) pc_q <= ZeroWord;
      else                  pc_q <= pc_d;
   end

endmodule

// File: rtl/tinyriscv_regs.sv
// rtl/tinyriscv_regs.sv - 32x32 integer register file, x0 hardwired to zero
module tinyriscv_regs
   import tinyriscv_pkg::*;
(
   input  logic     clk,
   input  logic     we_i,
   input  logic [4:0] waddr_i,
   input  reg_bus_t wdata_i,
   input  logic [4:0] raddr1_i,
   output reg_bus_t rdata1_o,
   input  logic [4:0] raddr2_i,
   output reg_bus_t rdata2_o
);

   logic [31:0] regs [0:31];

   assign rdata1_o = (raddr1_i == 5'd0) ? ZeroWord : regs[raddr1_i];
   assign rdata2_o = (raddr2_i == 5'd0) ? ZeroWord : regs[raddr2_i];

   // Write-back port; contents survive reset
   always_ff @(posedge clk) begin
      if (we_i && (waddr_i != 5'd0)) regs[waddr_i] <= wdata_i;
   end

endmodule

// File: rtl/tinyriscv_soc_top.sv
// rtl/tinyriscv_soc_top.sv - tinyriscv core with program ROM, data RAM and address decoder
module tinyriscv_soc_top
   import tinyriscv_pkg::*;
#(
   parameter int ROM_DEPTH = 4096,
   parameter int RAM_DEPTH = 4096
) (
   input  logic clk,
   input  logic rst,
   input  logic uart_debug_pin,
   output logic halted_ind
);

   reg_bus_t pc_addr, pc_data, ex_addr, ex_wdata, ex_rdata;
   logic     ex_we, ex_req, rom_we, ram_we;
   logic [IdxW-1:0] fetch_idx, data_idx;
   logic [31:0] rom_fetch_rdata, rom_data_rdata, ram_fetch_rdata, ram_data_rdata;
   logic halted_ind_d, halted_ind_q;

   tinyriscv u_tinyriscv (
      .clk             (clk),
      .rst             (rst),
      .pc_addr         (pc_addr),
      .pc_data         (pc_data),
      .ex_addr         (ex_addr),
      .ex_wdata        (ex_wdata),
      .ex_we           (ex_we),
      .ex_req          (ex_req),
      .ex_rdata        (ex_rdata),
      .rib_hold_flag_i (uart_debug_pin),
      .int_i           (1'b0)
   );

   soc_bus_decoder u_bus_decoder (
      .fetch_addr_i      (pc_addr),
      .fetch_data_o      (pc_data),
      .data_addr_i       (ex_addr),
      .data_req_i        (ex_req),
      .data_we_i         (ex_we),
      .data_rdata_o      (ex_rdata),
      .fetch_idx_o       (fetch_idx),
      .data_idx_o        (data_idx),
      .rom_fetch_rdata_i (rom_fetch_rdata),
      .rom_data_rdata_i  (rom_data_rdata),
      .ram_fetch_rdata_i (ram_fetch_rdata),
      .ram_data_rdata_i  (ram_data_rdata),
      .rom_we_o          (rom_we),
      .ram_we_o          (ram_we)
   );

   rom #(.DEPTH(ROM_DEPTH)) u_rom (
      .clk           (clk),
      .fetch_idx_i   (fetch_idx),
      .fetch_rdata_o (rom_fetch_rdata),
      .data_idx_i    (data_idx),
      .data_rdata_o  (rom_data_rdata),
      .we_i          (rom_we),
      .wdata_i       (ex_wdata)
   );

   ram #(.DEPTH(RAM_DEPTH)) u_ram (
      .clk           (clk),
      .fetch_idx_i   (fetch_idx),
      .fetch_rdata_o (ram_fetch_rdata),
      .data_idx_i    (data_idx),
      .data_rdata_o  (ram_data_rdata),
      .we_i          (ram_we),
      .wdata_i       (ex_wdata)
   );

   // Halt indicator follows the debug pin one clock later
   always_comb halted_ind_d = uart_debug_pin;

   // Halt indicator flop
   always_ff @(posedge clk) begin
      if (rst == RstEnable) halted_ind_q <= 1'b0;
      else                  halted_ind_q <= halted_ind_d;
   end

   assign halted_ind = halted_ind_q;

endmodule

// File: tb/tb_tinyriscv_soc_top.sv
// tb/tb_tinyriscv_soc_top.sv - randomized program-level checks of tinyriscv_soc_top
module tb_tinyriscv_soc_top;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic uart_debug_pin = 1'b0;
   logic halted_ind;

   int n_vec = 0;
   int n_err = 0;
   logic [31:0] prog [$];

   logic [2:0] op_f3  [10] = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd5, 3'd6, 3'd7};
   logic       op_alt [10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
   logic [2:0] br_f3  [6]  = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};

   tinyriscv_soc_top #(.ROM_DEPTH(4096), .RAM_DEPTH(4096)) dut (
      .clk            (clk),
      .rst            (rst),
      .uart_debug_pin (uart_debug_pin),
      .halted_ind     (halted_ind)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] e_i(input logic [11:0] imm, input logic [4:0] rs1,
                                       input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
      return {imm, rs1, f3, rd, op};
   endfunction
   function automatic logic [31:0] e_r(input logic alt, input logic [4:0] rs2, input logic [4:0] rs1,
                                       input logic [2:0] f3, input logic [4:0] rd);
      return {1'b0, alt, 5'b0, rs2, rs1, f3, rd, 7'h33};
   endfunction
   function automatic logic [31:0] e_s(input logic [11:0] imm, input logic [4:0] rs2,
                                       input logic [4:0] rs1, input logic [2:0] f3);
      return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
   endfunction
   function automatic logic [31:0] e_b(input logic [12:0] imm, input logic [4:0] rs2,
                                       input logic [4:0] rs1, input logic [2:0] f3);
      return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
   endfunction
   function automatic logic [31:0] e_j(input logic [20:0] imm, input logic [4:0] rd);
      return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
   endfunction

   // Reference arithmetic for the ten register-register operations, in table order
   function automatic logic [31:0] ref_op(input int k, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] r;
      case (k)
         0: r = a + b;
         1: r = a - b;
         2: r = a << b[4:0];
         3: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4: r = (a < b) ? 32'd1 : 32'd0;
         5: r = a ^ b;
         6: r = a >> b[4:0];
         7: r = $signed(a) >>> b[4:0];
         8: r = a | b;
         default: r = a & b;
      endcase
      return r;
   endfunction

   function automatic logic [31:0] sext12(input logic [11:0] v);
      return {{20{v[11]}}, v};
   endfunction

   task automatic li(input logic [4:0] rd, input logic [31:0] v);
      logic [31:0] up;
      up = (v + 32'h800) >> 12;
      prog.push_back({up[19:0], rd, 7'h37});
      prog.push_back(e_i(v[11:0], rd, 3'd0, rd, 7'h13));
   endtask

   task automatic halt_loop();
      prog.push_back(e_j(21'd0, 5'd0));
   endtask

   task automatic run_prog(input int cycles);
      @(negedge clk);
      rst = 1'b1;
      uart_debug_pin = 1'b0;
      foreach (prog[i]) dut.u_rom._rom[i] = prog[i];
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (cycles) @(negedge clk);
   endtask

   task automatic test_reset();
      prog.delete();
      repeat (3) prog.push_back(e_i(12'd0, 5'd0, 3'd0, 5'd0, 7'h13));
      halt_loop();
      @(negedge clk);
      rst = 1'b1;
      uart_debug_pin = 1'b1;
      foreach (prog[i]) dut.u_rom._rom[i] = prog[i];
      repeat (2) @(negedge clk);
      n_vec++;
      if (halted_ind !== 1'b0) begin n_err++; $display("FAIL reset_halted: got %b want 0", halted_ind); end
      rst = 1'b0;
      uart_debug_pin = 1'b0;
      n_vec++;
      if (dut.u_tinyriscv.pc_addr !== 32'h0) begin n_err++; $display("FAIL reset_first_fetch: got %h want 00000000", dut.u_tinyriscv.pc_addr); end
      @(negedge clk);
      n_vec++;
      if (dut.u_tinyriscv.pc_addr !== 32'h4) begin n_err++; $display("FAIL reset_pc_advance: got %h want 00000004", dut.u_tinyriscv.pc_addr); end
      n_vec++;
      if (halted_ind !== 1'b0) begin n_err++; $display("FAIL reset_halted_run: got %b want 0", halted_ind); end
   endtask

   task automatic test_alu();
      logic [31:0] a, b, got, exp;
      logic [11:0] imm;
      for (int it = 0; it < 4; it++) begin
         a = $urandom;
         b = (it == 0) ? a : $urandom;
         imm = 12'($urandom_range(0, 4095));
         prog.delete();
         li(5'd1, a);
         li(5'd2, b);
         for (int k = 0; k < 10; k++) prog.push_back(e_r(op_alt[k], 5'd2, 5'd1, op_f3[k], 5'(3 + k)));
         prog.push_back(e_i(imm, 5'd1, 3'd0, 5'd13, 7'h13));
         prog.push_back(e_i(imm, 5'd1, 3'd4, 5'd14, 7'h13));
         prog.push_back(e_i({7'h20, imm[4:0]}, 5'd1, 3'd5, 5'd15, 7'h13));
         halt_loop();
         run_prog(40);
         for (int k = 0; k < 13; k++) begin
            got = dut.u_tinyriscv.u_regs.regs[3 + k];
            if (k < 10)       exp = ref_op(k, a, b);
            else if (k == 10) exp = a + sext12(imm);
            else if (k == 11) exp = a ^ sext12(imm);
            else              exp = $signed(a) >>> imm[4:0];
            n_vec++;
            if (got !== exp) begin n_err++; $display("FAIL alu_x%0d a=%h b=%h imm=%h: got %h want %h", 3 + k, a, b, imm, got, exp); end
         end
      end
   endtask

   task automatic test_store_load();
      logic [31:0] v, got, exp;
      logic [31:0] exp_regs [3:8];
      for (int it = 0; it < 3; it++) begin
         v = (it == 0) ? 32'hDEADBEEF : $urandom;
         prog.delete();
         li(5'd1, 32'h1000_0000);
         li(5'd2, v);
         prog.push_back(e_s(12'd16, 5'd2, 5'd1, 3'd2));
         prog.push_back(e_i(12'd16, 5'd1, 3'd2, 5'd3, 7'h03));
         prog.push_back(e_s(12'd20, 5'd0, 5'd1, 3'd2));
         prog.push_back(e_s(12'd21, 5'd2, 5'd1, 3'd0));
         prog.push_back(e_i(12'd21, 5'd1, 3'd4, 5'd4, 7'h03));
         prog.push_back(e_i(12'd21, 5'd1, 3'd0, 5'd5, 7'h03));
         prog.push_back(e_i(12'd20, 5'd1, 3'd2, 5'd6, 7'h03));
         prog.push_back(e_s(12'd22, 5'd2, 5'd1, 3'd1));
         prog.push_back(e_i(12'd22, 5'd1, 3'd1, 5'd7, 7'h03));
         prog.push_back(e_i(12'd22, 5'd1, 3'd5, 5'd8, 7'h03));
         halt_loop();
         run_prog(40);
         exp_regs[3] = v;
         exp_regs[4] = v & 32'hFF;
         exp_regs[5] = {{24{v[7]}}, v[7:0]};
         exp_regs[6] = (v & 32'hFF) * 256;
         exp_regs[7] = {{16{v[15]}}, v[15:0]};
         exp_regs[8] = v & 32'hFFFF;
         for (int r = 3; r <= 8; r++) begin
            got = dut.u_tinyriscv.u_regs.regs[r];
            n_vec++;
            if (got !== exp_regs[r]) begin n_err++; $display("FAIL load_x%0d v=%h: got %h want %h", r, v, got, exp_regs[r]); end
         end
         n_vec++;
         if (dut.u_ram._ram[4] !== v) begin n_err++; $display("FAIL ram_word4: got %h want %h", dut.u_ram._ram[4], v); end
         exp = (v << 16) | ((v & 32'hFF) * 256);
         n_vec++;
         if (dut.u_ram._ram[5] !== exp) begin n_err++; $display("FAIL ram_word5_subword: got %h want %h", dut.u_ram._ram[5], exp); end
      end
   endtask

   task automatic test_unmapped();
      logic [31:0] v, snap [0:7];
      v = $urandom | 32'h1;
      prog.delete();
      li(5'd1, 32'h3000_0000);
      li(5'd4, 32'hF000_0000);
      li(5'd2, v);
      li(5'd3, 32'h1);
      li(5'd5, 32'h1);
      prog.push_back(e_s(12'd0, 5'd2, 5'd1, 3'd2));
      prog.push_back(e_i(12'd0, 5'd1, 3'd2, 5'd3, 7'h03));
      prog.push_back(e_s(12'd4, 5'd2, 5'd4, 3'd2));
      prog.push_back(e_i(12'd4, 5'd4, 3'd2, 5'd5, 7'h03));
      halt_loop();
      for (int i = 0; i < 8; i++) snap[i] = dut.u_ram._ram[i];
      run_prog(40);
      n_vec++;
      if (dut.u_tinyriscv.u_regs.regs[3] !== 32'h0) begin n_err++; $display("FAIL unmapped_load_3: got %h want 00000000", dut.u_tinyriscv.u_regs.regs[3]); end
      n_vec++;
      if (dut.u_tinyriscv.u_regs.regs[5] !== 32'h0) begin n_err++; $display("FAIL unmapped_load_f: got %h want 00000000", dut.u_tinyriscv.u_regs.regs[5]); end
      for (int i = 0; i < 8; i++) begin
         n_vec++;
         if (dut.u_ram._ram[i] !== snap[i]) begin n_err++; $display("FAIL unmapped_ram_%0d: got %h want %h", i, dut.u_ram._ram[i], snap[i]); end
      end
      for (int i = 0; i < 2; i++) begin
         n_vec++;
         if (dut.u_rom._rom[i] !== prog[i]) begin n_err++; $display("FAIL unmapped_rom_%0d: got %h want %h", i, dut.u_rom._rom[i], prog[i]); end
      end
   endtask

   task automatic test_branch_jump();
      logic [31:0] a, b, got;
      logic        taken;
      int          j, m;
      for (int it = 0; it < 6; it++) begin
         a = (it == 0) ? 32'h8000_0000 : $urandom;
         b = (it == 0) ? 32'h1 : (($urandom_range(0, 2) == 0) ? a : $urandom);
         prog.delete();
         li(5'd1, a);
         li(5'd2, b);
         for (int k = 0; k < 6; k++) begin
            prog.push_back(e_i(12'd0, 5'd0, 3'd0, 5'(10 + k), 7'h13));
            prog.push_back(e_b(13'd8, 5'd2, 5'd1, br_f3[k]));
            prog.push_back(e_i(12'd1, 5'd0, 3'd0, 5'(10 + k), 7'h13));
         end
         prog.push_back(e_i(12'd3, 5'd0, 3'd0, 5'd21, 7'h13));
         prog.push_back(e_i(12'd2, 5'd0, 3'd0, 5'd26, 7'h13));
         j = prog.size();
         prog.push_back(e_j(21'd8, 5'd20));
         prog.push_back(e_i(12'd7, 5'd0, 3'd0, 5'd21, 7'h13));
         prog.push_back(e_i(12'd5, 5'd0, 3'd0, 5'd22, 7'h13));
         m = prog.size();
         prog.push_back(e_i(12'(4 * (m + 2)), 5'd0, 3'd0, 5'd23, 7'h67));
         prog.push_back(e_i(12'd9, 5'd0, 3'd0, 5'd26, 7'h13));
         halt_loop();
         run_prog(60);
         for (int k = 0; k < 6; k++) begin
            case (k)
               0: taken = (a == b);
               1: taken = (a != b);
               2: taken = ($signed(a) < $signed(b));
               3: taken = ($signed(a) >= $signed(b));
               4: taken = (a < b);
               default: taken = (a >= b);
            endcase
            got = dut.u_tinyriscv.u_regs.regs[10 + k];
            n_vec++;
            if (got !== (taken ? 32'd0 : 32'd1)) begin n_err++; $display("FAIL branch_%0d a=%h b=%h: got %h want %h", k, a, b, got, taken ? 32'd0 : 32'd1); end
         end
         n_vec++;
         if (dut.u_tinyriscv.u_regs.regs[20] !== 32'(4 * j + 4)) begin n_err++; $display("FAIL jal_link: got %h want %h", dut.u_tinyriscv.u_regs.regs[20], 32'(4 * j + 4)); end
         n_vec++;
         if (dut.u_tinyriscv.u_regs.regs[21] !== 32'd3) begin n_err++; $display("FAIL jal_skip: got %h want 00000003", dut.u_tinyriscv.u_regs.regs[21]); end
         n_vec++;
         if (dut.u_tinyriscv.u_regs.regs[23] !== 32'(4 * m + 4)) begin n_err++; $display("FAIL jalr_link: got %h want %h", dut.u_tinyriscv.u_regs.regs[23], 32'(4 * m + 4)); end
         n_vec++;
         if (dut.u_tinyriscv.u_regs.regs[26] !== 32'd2) begin n_err++; $display("FAIL jalr_skip: got %h want 00000002", dut.u_tinyriscv.u_regs.regs[26]); end
      end
   endtask

   task automatic test_debug_hold();
      logic [31:0] pc_hold, x1_hold;
      prog.delete();
      prog.push_back(e_i(12'd0, 5'd0, 3'd0, 5'd1, 7'h13));
      prog.push_back(e_i(12'd1, 5'd1, 3'd0, 5'd1, 7'h13));
      prog.push_back(e_j(21'h1FFFFC, 5'd0));
      run_prog(10 + $urandom_range(0, 5));
      pc_hold = dut.u_tinyriscv.pc_addr;
      x1_hold = dut.u_tinyriscv.u_regs.regs[1];
      uart_debug_pin = 1'b1;
      n_vec++;
      if (halted_ind !== 1'b0) begin n_err++; $display("FAIL hold_lag: got %b want 0", halted_ind); end
      @(negedge clk);
      n_vec++;
      if (halted_ind !== 1'b1) begin n_err++; $display("FAIL hold_indicator: got %b want 1", halted_ind); end
      repeat (9) @(negedge clk);
      n_vec++;
      if (dut.u_tinyriscv.pc_addr !== pc_hold) begin n_err++; $display("FAIL hold_pc: got %h want %h", dut.u_tinyriscv.pc_addr, pc_hold); end
      n_vec++;
      if (dut.u_tinyriscv.u_regs.regs[1] !== x1_hold) begin n_err++; $display("FAIL hold_x1: got %h want %h", dut.u_tinyriscv.u_regs.regs[1], x1_hold); end
      uart_debug_pin = 1'b0;
      @(negedge clk);
      n_vec++;
      if (halted_ind !== 1'b0) begin n_err++; $display("FAIL hold_release_indicator: got %b want 0", halted_ind); end
      repeat (9) @(negedge clk);
      n_vec++;
      if (dut.u_tinyriscv.u_regs.regs[1] !== x1_hold + 32'd5) begin n_err++; $display("FAIL hold_resume_x1: got %h want %h", dut.u_tinyriscv.u_regs.regs[1], x1_hold + 32'd5); end
   endtask

   task automatic test_signature();
      logic [31:0] sig [4];
      logic        done;
      prog.delete();
      li(5'd1, 32'h0000_2000);
      for (int i = 0; i < 4; i++) begin
         sig[i] = $urandom;
         li(5'd2, sig[i]);
         prog.push_back(e_s(12'(4 * i), 5'd2, 5'd1, 3'd2));
      end
      li(5'd3, 32'h1000_0000);
      li(5'd2, 32'h0000_2000);
      prog.push_back(e_s(12'd8, 5'd2, 5'd3, 3'd2));
      li(5'd2, 32'h0000_2010);
      prog.push_back(e_s(12'd12, 5'd2, 5'd3, 3'd2));
      prog.push_back(e_i(12'd1, 5'd0, 3'd0, 5'd2, 7'h13));
      prog.push_back(e_s(12'd16, 5'd2, 5'd3, 3'd2));
      halt_loop();
      dut.u_ram._ram[4] = 32'h0;
      run_prog(0);
      done = 1'b0;
      for (int c = 0; c < 300 && !done; c++) begin
         @(negedge clk);
         if (dut.u_ram._ram[4] === 32'd1) done = 1'b1;
      end
      n_vec++;
      if (!done) begin n_err++; $display("FAIL signature_done: got %h want 00000001", dut.u_ram._ram[4]); end
      for (int i = 0; i < 4; i++) begin
         n_vec++;
         if (dut.u_rom._rom[12'h800 + i] !== sig[i]) begin n_err++; $display("FAIL signature_%0d: got %h want %h", i, dut.u_rom._rom[12'h800 + i], sig[i]); end
      end
      n_vec++;
      if (dut.u_ram._ram[2] !== 32'h2000) begin n_err++; $display("FAIL signature_begin: got %h want 00002000", dut.u_ram._ram[2]); end
      n_vec++;
      if (dut.u_ram._ram[3] !== 32'h2010) begin n_err++; $display("FAIL signature_end: got %h want 00002010", dut.u_ram._ram[3]); end
   endtask

   initial begin
      test_reset();
      test_alu();
      test_store_load();
      test_unmapped();
      test_branch_jump();
      test_debug_hold();
      test_signature();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/tinyriscv_soc_top.md
# tinyriscv_soc_top

Top-level SoC wrapper for the tinyriscv RV32I core. It instantiates the core, a program ROM and a data RAM, plus a single-master address decoder, and exposes only clock, reset, a debug-hold pin and a halt indicator. The compliance and program benches drive this block directly. They load the ROM and probe the core register file and both memory arrays by hierarchical path.

## Interface
- ROM_DEPTH, 4096: ROM size in 32-bit words.
- RAM_DEPTH, 4096: RAM size in 32-bit words.
- clk  in  1  system clock.
- rst  in  1  reset. One clock; reset is synchronous and active-high.
- uart_debug_pin  in  1  1 = hold the core (debug/download mode); 0 = run.
- halted_ind  out  1  registered copy of uart_debug_pin; reset value 0.

## Operation
- Instance names and arrays are fixed; benches depend on them:
  - u_tinyriscv: core. Register file is u_tinyriscv.u_regs.regs[0:31], 32-bit.
  - u_rom: ROM. Array _rom[0:ROM_DEPTH-1], 32-bit.
  - u_ram: RAM. Array _ram[0:RAM_DEPTH-1], 32-bit.
- Core-side ports used:
  - Instruction fetch: pc_addr, returns pc_data.
  - Data port: ex_addr, ex_wdata, ex_we, ex_req, returns ex_rdata.
  - rib_hold_flag_i: hold input.
  - int_i: interrupt input, tied to 0.
- Address decode on addr[31:28], applied to both fetch and data ports:
  - 0x0: ROM, word index addr[13:2].
  - 0x1: RAM, word index addr[13:2].
  - Any other region: read returns 32'h0; write is dropped.
- The ROM is writable from the data port, so program stores and signature writes land in it.
- Fetch and data ports read the ROM independently (two read ports). There is no arbitration and no stall.
- Reads are combinational from the word index. Writes commit full words at the posedge when ex_req & ex_we are both set.
- Byte/halfword stores are handled by the core via read-modify-write; the memories see only full words.
- Word index uses low bits only; higher offsets wrap inside the array.
- Debug hold: rib_hold_flag_i = uart_debug_pin. While high, the core's PC and pipeline freeze and no memory writes are issued.
- Software end-of-test convention. The block only guarantees these words are writable and visible at the stated array indices:
  - RAM word 2 = signature begin address.
  - RAM word 3 = signature end address.
  - RAM word 4 = 1 means done.

## Timing
- Reset (rst = 1 at a posedge):
  - Core PC returns to 0x0000_0000 and the pipeline is flushed.
  - halted_ind goes to 0.
  - Memory arrays are not cleared; ROM contents loaded before time 0 persist.
- First fetch from address 0 occurs on the first posedge after rst deasserts.
- Read data is valid in the same cycle the address is presented.
- A write is visible to a read of the same address on the next cycle.
- If a write and a read hit the same word in the same cycle, the read returns the old value.
- halted_ind lags uart_debug_pin by one clock.
- Reset asserted mid-store: that cycle's write is still committed if ex_we was high at the edge. Reset does not gate memory writes.

## Structure
- Shared package (tinyriscv defines):
  - RegBus width (31:0).
  - Region codes: ROM 4'h0, RAM 4'h1.
  - Reset polarity constants: RstEnable = 1, RstDisable = 0.
  - ZeroWord.
- One natural new sub-module: soc_bus_decoder. It does region select, read-data mux and write-enable gating for the fetch and data ports.
- Core, rom and ram are existing modules.

## Test plan
- Reset: hold rst = 1 for 2 cycles, then release. Expect halted_ind = 0 and fetch address 0x0 on the first cycle after release.
- Store/load: program stores 0xDEADBEEF to 0x1000_0010. Expect _ram[4] = 0xDEADBEEF next cycle; a following lw returns it into a register.
- Signature flow: program writes signature data into ROM 0x0000_2000–0x0000_200C. It then writes 0x2000 to RAM word 2, 0x2010 to RAM word 3 and 1 to RAM word 4. The bench waits for _ram[4] == 1 and dumps _rom[0x800..0x803] with the expected values.
- Unmapped region: sw to 0x3000_0000 then lw from it. Expect 0 loaded; no ROM/RAM word changes.
- Debug hold: raise uart_debug_pin mid-loop for 10 cycles. Expect halted_ind = 1 one cycle later, PC and registers frozen, and execution resuming from the same PC after release.
- Register-test program: completion sets x26 = 1 and x27 = 1 within 500 µs at a 50 MHz clock; a failure leaves x27 = 0 and x3 = failing test number.
